// File: rtl/stopwatch_if.sv
// Button inputs and datapath control outputs of the stopwatch sequencer.
// The master side (board/bench) drives buttons; the slave side (sequencer) drives controls.
interface stopwatch_if;
    logic       btn_ss;
    logic       btn_lap;
    logic       btn_clr;
    logic       count_en;
    logic       count_clr;
    logic       latch_en;
    logic [1:0] state_out;

    modport master (
        output btn_ss, btn_lap, btn_clr,
        input  count_en, count_clr, latch_en, state_out
    );

    modport slave (
        input  btn_ss, btn_lap, btn_clr,
        output count_en, count_clr, latch_en, state_out
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button sync/debounce, start/pause/lap/clear FSM,
// one-second prescaler and datapath control strobes.
module stopwatch_ctrl #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    stopwatch_if.slave  sw
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] LAP   = 2'b11;

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int PS_W = $clog2(TICK_DIV);

    localparam int B_SS  = 0;
    localparam int B_LAP = 1;
    localparam int B_CLR = 2;

    logic [2:0]      btn_raw;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      deb_q, deb_d, deb_prev_q;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];
    logic [2:0]      press;

    logic [1:0]      state_q, state_d;
    logic [PS_W-1:0] presc_q, presc_d;
    logic            clr_q, clr_d;
    logic            latch_q, latch_d;
    logic            running, tick;

    assign btn_raw = {sw.btn_clr, sw.btn_lap, sw.btn_ss};

    // The counter only runs while the synchronised value disagrees with the accepted level.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        for (int i = 0; i < 3; i++) begin
            deb_d[i]    = deb_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1))
                    deb_d[i] = ~deb_q[i];
                else
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    assign press   = deb_q & ~deb_prev_q;
    assign running = (state_q == RUN) || (state_q == LAP);
    assign tick    = running && (presc_q == PS_W'(TICK_DIV - 1));

    // Presses are taken in priority order clr > ss > lap; a press invalid in this state falls through.
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (press[B_CLR])     clr_d   = 1'b1;
                else if (press[B_SS]) state_d = RUN;
            end
            RUN: begin
                if (press[B_SS])       state_d = PAUSE;
                else if (press[B_LAP]) state_d = LAP;
            end
            LAP: begin
                if (press[B_SS])       state_d = PAUSE;
                else if (press[B_LAP]) state_d = RUN;
            end
            PAUSE: begin
                if (press[B_CLR]) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end else if (press[B_SS]) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE)
            presc_d = '0;
        else if (running)
            presc_d = tick ? '0 : presc_q + 1'b1;
        else
            presc_d = presc_q;

        latch_d = (state_d != LAP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
            state_q    <= IDLE;
            presc_q    <= '0;
            clr_q      <= 1'b0;
            latch_q    <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
            state_q    <= state_d;
            presc_q    <= presc_d;
            clr_q      <= clr_d;
            latch_q    <= latch_d;
        end
    end

    assign sw.count_en  = tick;
    assign sw.count_clr = clr_q;
    assign sw.latch_en  = latch_q;
    assign sw.state_out = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random button traffic,
// all compared cycle by cycle against a behavioural model of the stopwatch rules.
module tb_stopwatch_ctrl;
    localparam int TICK_DIV = 10;
    localparam int DEB      = 4;

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3;
    localparam int K_SS = 0, K_LAP = 1, K_CLR = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stopwatch_if sw ();

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYC(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw)
    );

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int clr_cnt = 0;

    // Behavioural model: button delay line, run-length debounce, rule-table FSM, phase counter.
    bit [2:0] m_s1, m_s2, m_lvl, m_prev;
    int       m_run [3];
    int       m_st;
    int       m_phase;
    bit       m_clr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_running(input int st);
        return (st == S_RUN) || (st == S_LAP);
    endfunction

    function automatic bit press_valid(input int st, input int k);
        case (k)
            K_CLR:   return (st == S_IDLE) || (st == S_PAUSE);
            K_SS:    return 1'b1;
            default: return is_running(st);
        endcase
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
        m_st = S_IDLE; m_phase = 0; m_clr = 1'b0;
    endtask

    task automatic model_step(input bit [2:0] b);
        bit [2:0] pr;
        int order [3];
        int act, nst, nphase;
        pr = m_lvl & ~m_prev;
        order = '{K_CLR, K_SS, K_LAP};
        act = -1;
        nst = m_st;
        for (int k = 0; k < 3; k++)
            if (act < 0 && pr[order[k]] && press_valid(m_st, order[k])) act = order[k];
        case (act)
            K_CLR: nst = S_IDLE;
            K_SS:  nst = is_running(m_st) ? S_PAUSE : S_RUN;
            K_LAP: nst = (m_st == S_RUN) ? S_LAP : S_RUN;
            default: ;
        endcase
        nphase = is_running(m_st) ? (m_phase + 1) % TICK_DIV : m_phase;
        if (nst == S_IDLE) nphase = 0;
        for (int i = 0; i < 3; i++) begin
            m_prev[i] = m_lvl[i];
            m_run[i]  = (m_s2[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
            if (m_run[i] == DEB) begin
                m_lvl[i] = ~m_lvl[i];
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = b;
        m_clr = (act == K_CLR);
        m_st = nst;
        m_phase = nphase;
    endtask

    task automatic compare_outputs(input string where);
        check({where, ".count_en"},  sw.count_en,  is_running(m_st) && m_phase == TICK_DIV - 1);
        check({where, ".count_clr"}, sw.count_clr, m_clr);
        check({where, ".latch_en"},  sw.latch_en,  m_st != S_LAP);
        check({where, ".state_out"}, sw.state_out, m_st);
    endtask

    task automatic set_btn(input bit [2:0] b);
        sw.btn_ss  = b[K_SS];
        sw.btn_lap = b[K_LAP];
        sw.btn_clr = b[K_CLR];
    endtask

    // One clock: model follows the same edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step({sw.btn_clr, sw.btn_lap, sw.btn_ss});
        @(negedge clk);
        compare_outputs("cyc");
        en_cnt  += int'(sw.count_en);
        clr_cnt += int'(sw.count_clr);
    endtask

    task automatic hold(input bit [2:0] b, input int n);
        set_btn(b);
        repeat (n) cycle();
        set_btn(3'b000);
    endtask

    task automatic async_reset_check(input string where);
        #2 reset = 1'b1;
        #1 model_reset();
        compare_outputs(where);
    endtask

    task automatic wait_phase(input int ph);
        int budget;
        budget = 4 * TICK_DIV;
        while (m_phase != ph && budget > 0) begin
            cycle();
            budget--;
        end
        if (budget == 0) check("wait_phase_timeout", 0, 1);
    endtask

    initial begin
        int t_left [3];
        bit [2:0] lvl;

        reset = 1'b1;
        set_btn(3'b000);
        #1 model_reset();
        compare_outputs("reset");
        repeat (3) cycle();
        reset = 1'b0;

        // Glitch shorter than the debounce window
        hold(3'b001, 2);
        repeat (10) cycle();
        check("glitch_state", sw.state_out, S_IDLE);

        // Start, then count ticks over 40 running cycles
        hold(3'b001, 20);
        check("start_state", sw.state_out, S_RUN);
        en_cnt = 0;
        repeat (40) cycle();
        check("run_ticks_40", en_cnt, 4);

        // Pause with phase 6 at the press, resume after 50 cycles
        wait_phase(0);
        hold(3'b001, 8);
        en_cnt = 0;
        repeat (50) cycle();
        check("pause_state", sw.state_out, S_PAUSE);
        check("pause_no_tick", en_cnt, 0);
        check("pause_phase_held", m_phase, 7);
        hold(3'b001, 8);
        repeat (20) cycle();
        check("resume_state", sw.state_out, S_RUN);

        // Lap split and return
        hold(3'b010, 8);
        check("lap_latch", sw.latch_en, 1'b0);
        check("lap_state", sw.state_out, S_LAP);
        en_cnt = 0;
        repeat (30) cycle();
        check("lap_ticks_30", en_cnt, 3);
        hold(3'b010, 8);
        check("unlap_latch", sw.latch_en, 1'b1);
        check("unlap_state", sw.state_out, S_RUN);

        // Pause, then clr+ss together: clear wins
        hold(3'b001, 8);
        check("pause2_state", sw.state_out, S_PAUSE);
        clr_cnt = 0;
        hold(3'b101, 8);
        repeat (4) cycle();
        check("clr_state", sw.state_out, S_IDLE);
        check("clr_pulses", clr_cnt, 1);

        // Reset while running with prescaler at 8
        hold(3'b001, 8);
        wait_phase(8);
        async_reset_check("midrun_reset");
        cycle();
        reset = 1'b0;
        en_cnt = 0;
        repeat (100) cycle();
        check("post_reset_state", sw.state_out, S_IDLE);
        check("post_reset_ticks", en_cnt, 0);

        // Random button traffic with occasional resets
        for (int i = 0; i < 3; i++) t_left[i] = 0;
        lvl = '0;
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (t_left[i] == 0) begin
                    lvl[i]    = ($urandom_range(0, 2) == 0);
                    t_left[i] = $urandom_range(1, 12);
                end
                t_left[i]--;
            end
            set_btn(lvl);
            if ($urandom_range(0, 599) == 0) begin
                async_reset_check("rand_reset");
                cycle();
                reset = 1'b0;
            end else begin
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
